lcd_msg_gen: RTL



---
 rtl/lcd_pkg.sv | 68 ++++++
 rtl/lcd_msg_gen_if.sv | 10 +
 rtl/bin2bcd.sv | 54 +++++
 rtl/lcd_msg_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state type and byte-stream helpers for the LCD message generator.
// Build option: define LCD_LZB_EN to blank leading zero digits in displayed values.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_A    = 8'h61;
  localparam logic [7:0] ASCII_B    = 8'h62;
  localparam logic [7:0] ASCII_C    = 8'h63;

  localparam int unsigned MSG_LEN = 19;

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  // Three BCD digits (hundreds in the top nibble) to three ASCII characters.
  function automatic logic [23:0] to_ascii3(input logic [11:0] bcd);
    logic [23:0] txt;
    txt = {ASCII_ZERO | {4'h0, bcd[11:8]},
           ASCII_ZERO | {4'h0, bcd[7:4]},
           ASCII_ZERO | {4'h0, bcd[3:0]}};
`ifdef LCD_LZB_EN
    if (bcd[11:8] == 4'd0) begin
      txt[23:16] = ASCII_SP;
      if (bcd[7:4] == 4'd0) txt[15:8] = ASCII_SP;
    end
`else
    txt = txt;
`endif
    return txt;
  endfunction

  // Byte idx of the display stream as {rs, data}.
  function automatic logic [8:0] msg_byte(input logic [4:0]  idx,
                                          input logic [23:0] a_txt,
                                          input logic [23:0] b_txt,
                                          input logic [23:0] c_txt);
    logic [8:0] r;
    case (idx)
      5'd0:    r = {1'b0, LCD_CMD_CLEAR};
      5'd1:    r = {1'b0, LCD_CMD_LINE1};
      5'd2:    r = {1'b1, ASCII_A};
      5'd3:    r = {1'b1, ASCII_EQ};
      5'd4:    r = {1'b1, a_txt[23:16]};
      5'd5:    r = {1'b1, a_txt[15:8]};
      5'd6:    r = {1'b1, a_txt[7:0]};
      5'd7:    r = {1'b1, ASCII_SP};
      5'd8:    r = {1'b1, ASCII_B};
      5'd9:    r = {1'b1, ASCII_EQ};
      5'd10:   r = {1'b1, b_txt[23:16]};
      5'd11:   r = {1'b1, b_txt[15:8]};
      5'd12:   r = {1'b1, b_txt[7:0]};
      5'd13:   r = {1'b0, LCD_CMD_LINE2};
      5'd14:   r = {1'b1, ASCII_C};
      5'd15:   r = {1'b1, ASCII_EQ};
      5'd16:   r = {1'b1, c_txt[23:16]};
      5'd17:   r = {1'b1, c_txt[15:8]};
      5'd18:   r = {1'b1, c_txt[7:0]};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_msg_gen_if.sv
// Byte stream from the message generator to the HD44780 4-bit writer.
interface lcd_msg_gen_if;
  logic       out_valid;
  logic       out_ready;
  logic       out_rs;
  logic [7:0] out_data;

  modport master (output out_valid, output out_rs, output out_data, input out_ready);
  modport slave  (input out_valid, input out_rs, input out_data, output out_ready);
endinterface

// File: rtl/bin2bcd.sv
// Sequential double-dabble: load performs the first shift, then IN_W-1 shift/add-3 steps.
module bin2bcd #(
    parameter int unsigned IN_W   = 9,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [IN_W-1:0]       bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int unsigned SW = $clog2(IN_W + 1);
    localparam logic [SW-1:0] LAST = SW'(IN_W - 1);

    logic [IN_W-1:0]     sh_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] adj;
    logic [SW-1:0]       step_q;
    logic                active_q;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q     <= '0;
            bcd_q    <= '0;
            step_q   <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            // BCD is empty on load, so the first bit shifts in without adjustment.
            sh_q     <= bin << 1;
            bcd_q    <= {{(4*DIGITS-1){1'b0}}, bin[IN_W-1]};
            step_q   <= '0;
            active_q <= 1'b1;
        end else if (active_q && step_q != LAST) begin
            bcd_q  <= {adj[4*DIGITS-2:0], sh_q[IN_W-1]};
            sh_q   <= sh_q << 1;
            step_q <= step_q + 1'b1;
        end else begin
            active_q <= 1'b0;
        end
    end

    assign bcd  = bcd_q;
    assign done = active_q && (step_q == LAST);

endmodule

// File: rtl/lcd_msg_gen.sv
// Latches a and b, converts a, b and a+b to decimal, and streams the 19-byte LCD message.
// Build option: LCD_LZB_EN enables leading-zero blanking (see lcd_pkg::to_ascii3).
module lcd_msg_gen
    import lcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    lcd_msg_gen_if.master     msg
);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [4:0]        idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH:0]    c_q, c_d;
    logic [23:0]       a_txt_q, a_txt_d, b_txt_q, b_txt_d, c_txt_q, c_txt_d;
    logic              valid_q, valid_d, rs_q, rs_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]        data_q, data_d;

    logic                cv_load, cv_done;
    logic [WIDTH:0]      cv_bin;
    logic [4*DIGITS-1:0] cv_bcd;

    bin2bcd #(
        .IN_W   (WIDTH + 1),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk  (clk),
        .rst  (rst),
        .load (cv_load),
        .bin  (cv_bin),
        .bcd  (cv_bcd),
        .done (cv_done)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        a_txt_d = a_txt_q;
        b_txt_d = b_txt_q;
        c_txt_d = c_txt_q;
        valid_d = valid_q;
        rs_d    = rs_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cv_load = 1'b0;
        cv_bin  = {1'b0, a_q};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = {1'b0, a} + {1'b0, b};
                    busy_d  = 1'b1;
                    sel_d   = 2'd0;
                    idx_d   = 5'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                // sel: 0 = load a, 1/2/3 = converting a/b/c; each finish loads the next value.
                case (sel_q)
                    2'd0: begin
                        cv_load = 1'b1;
                        sel_d   = 2'd1;
                    end
                    2'd1: if (cv_done) begin
                        a_txt_d = to_ascii3(cv_bcd[11:0]);
                        cv_load = 1'b1;
                        cv_bin  = {1'b0, b_q};
                        sel_d   = 2'd2;
                    end
                    2'd2: if (cv_done) begin
                        b_txt_d = to_ascii3(cv_bcd[11:0]);
                        cv_load = 1'b1;
                        cv_bin  = c_q;
                        sel_d   = 2'd3;
                    end
                    default: if (cv_done) begin
                        c_txt_d          = to_ascii3(cv_bcd[11:0]);
                        idx_d            = 5'd0;
                        {rs_d, data_d}   = msg_byte(5'd0, a_txt_q, b_txt_q, c_txt_q);
                        valid_d          = 1'b1;
                        state_d          = EMIT;
                    end
                endcase
            end
            EMIT: begin
                if (valid_q && msg.out_ready) begin
                    if (idx_q == 5'(MSG_LEN - 1)) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d          = idx_q + 5'd1;
                        {rs_d, data_d} = msg_byte(idx_q + 5'd1, a_txt_q, b_txt_q, c_txt_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            idx_q   <= 5'd0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            a_txt_q <= '0;
            b_txt_q <= '0;
            c_txt_q <= '0;
            valid_q <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            a_txt_q <= a_txt_d;
            b_txt_q <= b_txt_d;
            c_txt_q <= c_txt_d;
            valid_q <= valid_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign msg.out_valid = valid_q;
    assign msg.out_rs    = rs_q;
    assign msg.out_data  = data_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
